wave_param_loader: RTL and testbench
====================================

WAVE_PARAM_LOADER -- requirements
Module: wave_param_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: idle cycles allowed mid-frame before abort, range 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock, all logic rising-edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 8: command/payload byte.
REQ-005 SHALL have port in_valid, input, 1: in_data valid.
REQ-006 SHALL have port in_ready, output, 1: byte accepted on any edge where in_valid and in_ready are both 1.
REQ-007 SHALL have port amps, output, 32: active amplitudes, ch1 [31:16], ch0 [15:0], two's complement, passed through uninterpreted.
REQ-008 SHALL have port offsets, output, 32: active phase offsets, same channel packing.
REQ-009 SHALL have port phasewords, output, 32: active phase increments, same channel packing.
REQ-010 SHALL have port commit_pulse, output, 1: one-cycle strobe when active registers update.
REQ-011 SHALL have port frame_err, output, 1: one-cycle strobe on a bad header or a timeout.

Function
REQ-012 Header byte layout SHALL be: [7:6] field (00 amp, 01 offset, 10 phase, 11 commit), [5:4] reserved-or-channel, [3:0] reserved.
- [4] is the channel (0 = low half, 1 = high half).
- [5] and [3:0] are reserved and must be 0.
REQ-013 Write frame SHALL be: header, then data MSB byte, then data LSB byte; the 16-bit word is written to the selected shadow half on LSB acceptance.
REQ-014 Commit frame SHALL be the header only; bit [4] is ignored.
REQ-015 FSM states SHALL be IDLE, MSB, LSB, COMMIT.
- IDLE to MSB on a valid write header.
- MSB to LSB on byte acceptance.
- LSB to IDLE on byte acceptance, with shadow write.
- IDLE to COMMIT on a commit header.
- COMMIT to IDLE unconditionally after one cycle.
REQ-016 in_ready SHALL be 1 in IDLE, MSB and LSB, and 0 in COMMIT.
REQ-017 At the COMMIT-to-IDLE edge, amps, offsets and phasewords SHALL all load from shadow atomically, and commit_pulse SHALL be 1 for the following cycle.
REQ-018 Outputs SHALL change only at commit; shadow writes are never visible before commit.
REQ-019 A header accepted in IDLE with nonzero reserved bits SHALL be dropped, frame_err pulses the next cycle, and the state stays IDLE.
REQ-020 A timeout counter SHALL clear on every accepted byte and increment each cycle in MSB or LSB without acceptance.
- At count TIMEOUT-1, the state returns to IDLE, frame_err pulses the next cycle, and shadow is unchanged.
REQ-021 If a byte is accepted in the same cycle the counter reaches TIMEOUT-1, the byte SHALL win: normal transition, no error.
REQ-022 A partial frame SHALL never modify shadow.
- Shadow is written only on LSB acceptance.
- The MSB byte is held in a holding register.
REQ-023 Writing the same shadow half twice before commit SHALL keep the last value.

Reset
REQ-024 While reset is 0, the following SHALL hold:
- state is IDLE.
- amps, offsets, phasewords, shadow, holding register and timeout counter are 0.
- commit_pulse and frame_err are 0.
- in_ready is 1.
REQ-025 Reset assertion mid-frame or in COMMIT SHALL discard the frame with no commit and no frame_err after release.

Structure
REQ-026 A shared package wave_pkg SHALL hold the following:
- field codes (FLD_AMP, FLD_OFS, FLD_PHS, FLD_COMMIT).
- the state enum.
- header bit positions.
- CHAN_W = 16 and the channel count of 2.
REQ-027 The block SHALL be a single module; no sub-module is required.

Verification
REQ-028 Apply reset, then release: all outputs are 0, in_ready is 1, and no strobes occur.
REQ-029 Send bytes 0x10, 0x7F, 0xFF, then 0xC0: amps stays 0 until commit, then becomes 0x7FFF0000, and commit_pulse is high for exactly 1 cycle.
REQ-030 Send header 0x21: frame_err pulses once and outputs do not change; then the frame 0x80, 0x12, 0x34 plus 0xC0 gives phasewords = 0x00001234.
REQ-031 Send 0x40, 0x12, then idle for TIMEOUT cycles: frame_err pulses once; a following 0xC0 gives offsets = 0.
REQ-032 Hold in_valid with 0xC0 followed by 0x00: in_ready is 0 for one cycle during COMMIT and the 0x00 header is accepted the next cycle.
REQ-033 Assert reset after 0x00, 0xAB: after release, 0xC0 gives amps = 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform parameter loader:
// header field codes, bit positions, FSM states and channel geometry.
package wave_pkg;

    localparam int CHAN_W   = 16;
    localparam int NUM_CHAN = 2;

    localparam int HDR_FLD_HI   = 7;
    localparam int HDR_FLD_LO   = 6;
    localparam int HDR_RSV_BIT  = 5;
    localparam int HDR_CHAN_BIT = 4;
    localparam int HDR_RSV_HI   = 3;

    typedef enum logic [1:0] {
        FLD_AMP    = 2'b00,
        FLD_OFS    = 2'b01,
        FLD_PHS    = 2'b10,
        FLD_COMMIT = 2'b11
    } fld_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MSB    = 2'd1,
        ST_LSB    = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    function automatic logic hdr_rsv_bad(input logic [7:0] h);
        return h[HDR_RSV_BIT] | (|h[HDR_RSV_HI:0]);
    endfunction

endpackage

// File: rtl/wave_param_loader.sv
// Byte-stream loader for two-channel waveform parameters: write frames
// fill a shadow bank, a commit frame copies it to the active outputs.
module wave_param_loader
    import wave_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] amps,
    output logic [31:0] offsets,
    output logic [31:0] phasewords,
    output logic        commit_pulse,
    output logic        frame_err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    fld_e        fld_q, fld_d;
    logic        chan_q, chan_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] shd_amp_q, shd_amp_d;
    logic [31:0] shd_ofs_q, shd_ofs_d;
    logic [31:0] shd_phs_q, shd_phs_d;
    logic [31:0] amps_q, amps_d;
    logic [31:0] ofs_q, ofs_d;
    logic [31:0] phs_q, phs_d;
    logic        commit_q, commit_d;
    logic        err_q, err_d;
    logic        acc;
    logic [15:0] word;

    assign in_ready     = (state_q != ST_COMMIT);
    assign acc          = in_valid & in_ready;
    assign word         = {hold_q, in_data};
    assign amps         = amps_q;
    assign offsets      = ofs_q;
    assign phasewords   = phs_q;
    assign commit_pulse = commit_q;
    assign frame_err    = err_q;

    always_comb begin
        state_d   = state_q;
        fld_d     = fld_q;
        chan_d    = chan_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        shd_amp_d = shd_amp_q;
        shd_ofs_d = shd_ofs_q;
        shd_phs_d = shd_phs_q;
        amps_d    = amps_q;
        ofs_d     = ofs_q;
        phs_d     = phs_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (acc) begin
                    if (hdr_rsv_bad(in_data)) begin
                        err_d = 1'b1;
                    end else if (fld_e'(in_data[HDR_FLD_HI:HDR_FLD_LO]) == FLD_COMMIT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_MSB;
                        fld_d   = fld_e'(in_data[HDR_FLD_HI:HDR_FLD_LO]);
                        chan_d  = in_data[HDR_CHAN_BIT];
                    end
                end
            end
            ST_MSB, ST_LSB: begin
                if (acc) begin
                    tmo_d = '0;
                    if (state_q == ST_MSB) begin
                        hold_d  = in_data;
                        state_d = ST_LSB;
                    end else begin
                        state_d = ST_IDLE;
                        unique case (fld_q)
                            FLD_AMP: begin
                                if (chan_q) shd_amp_d[31:16] = word;
                                else        shd_amp_d[15:0]  = word;
                            end
                            FLD_OFS: begin
                                if (chan_q) shd_ofs_d[31:16] = word;
                                else        shd_ofs_d[15:0]  = word;
                            end
                            FLD_PHS: begin
                                if (chan_q) shd_phs_d[31:16] = word;
                                else        shd_phs_d[15:0]  = word;
                            end
                            default: ;
                        endcase
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort: the half-built frame is dropped, shadow untouched.
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_COMMIT: begin
                amps_d   = shd_amp_q;
                ofs_d    = shd_ofs_q;
                phs_d    = shd_phs_q;
                commit_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            fld_q     <= FLD_AMP;
            chan_q    <= 1'b0;
            hold_q    <= '0;
            tmo_q     <= '0;
            shd_amp_q <= '0;
            shd_ofs_q <= '0;
            shd_phs_q <= '0;
            amps_q    <= '0;
            ofs_q     <= '0;
            phs_q     <= '0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fld_q     <= fld_d;
            chan_q    <= chan_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            shd_amp_q <= shd_amp_d;
            shd_ofs_q <= shd_ofs_d;
            shd_phs_q <= shd_phs_d;
            amps_q    <= amps_d;
            ofs_q     <= ofs_d;
            phs_q     <= phs_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_wave_param_loader.sv
// Directed bench for wave_param_loader: frames, commit, bad headers,
// timeout boundary, back-to-back headers and mid-frame reset.
module tb_wave_param_loader;

    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] amps;
    logic [31:0] offsets;
    logic [31:0] phasewords;
    logic        commit_pulse;
    logic        frame_err;

    int errors;
    int checks;
    int err_cnt;
    int cmt_cnt;

    wave_param_loader #(.TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .amps        (amps),
        .offsets     (offsets),
        .phasewords  (phasewords),
        .commit_pulse(commit_pulse),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        err_cnt = 0;
        cmt_cnt = 0;
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (commit_pulse === 1'b1) cmt_cnt <= cmt_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: byte %h in_ready=%b want 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({amps, offsets, phasewords} !== 96'h0) begin
            errors++;
            $display("FAIL reset_outs: got %h %h %h want 0", amps, offsets, phasewords);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        checks++;
        if ({commit_pulse, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_strobes: got %b%b want 00", commit_pulse, frame_err);
        end
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        checks++;
        if (err_cnt !== 0 || cmt_cnt !== 0) begin
            errors++;
            $display("FAIL reset_release: err=%0d cmt=%0d want 0 0", err_cnt, cmt_cnt);
        end
    endtask

    task automatic test_amp_commit;
        int c0;
        c0 = cmt_cnt;
        send(8'h10);
        send(8'h7F);
        send(8'hFF);
        checks++;
        if (amps !== 32'h0) begin
            errors++;
            $display("FAIL amp_shadow_hidden: got %h want 00000000", amps);
        end
        send(8'hC0);
        checks++;
        if (in_ready !== 1'b0 || amps !== 32'h0) begin
            errors++;
            $display("FAIL amp_in_commit: ready=%b amps=%h want 0 00000000", in_ready, amps);
        end
        idle(1);
        checks++;
        if (amps !== 32'h7FFF0000 || commit_pulse !== 1'b1) begin
            errors++;
            $display("FAIL amp_commit: amps=%h pulse=%b want 7fff0000 1", amps, commit_pulse);
        end
        idle(1);
        checks++;
        if (commit_pulse !== 1'b0 || cmt_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL amp_pulse_width: pulse=%b count=%0d want 0 1", commit_pulse, cmt_cnt - c0);
        end
    endtask

    task automatic test_double_write;
        send(8'h00);
        send(8'h11);
        send(8'h11);
        send(8'h00);
        send(8'h22);
        send(8'h22);
        send(8'hC0);
        idle(1);
        checks++;
        if (amps !== 32'h7FFF2222) begin
            errors++;
            $display("FAIL double_write: got %h want 7fff2222", amps);
        end
    endtask

    task automatic test_bad_header;
        int e0;
        e0 = err_cnt;
        send(8'h21);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_hdr_err: got %b want 1", frame_err);
        end
        idle(2);
        checks++;
        if (err_cnt - e0 !== 1 || amps !== 32'h7FFF2222 || phasewords !== 32'h0) begin
            errors++;
            $display("FAIL bad_hdr_after: errs=%0d amps=%h phs=%h want 1 7fff2222 0",
                     err_cnt - e0, amps, phasewords);
        end
        send(8'h80);
        send(8'h12);
        send(8'h34);
        send(8'hC0);
        idle(1);
        checks++;
        if (phasewords !== 32'h00001234 || amps !== 32'h7FFF2222) begin
            errors++;
            $display("FAIL phase_write: phs=%h amps=%h want 00001234 7fff2222", phasewords, amps);
        end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send(8'h40);
        send(8'h12);
        repeat (T - 1) @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b want 0", frame_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err: got %b want 1", frame_err);
        end
        idle(2);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL timeout_count: got %0d want 1", err_cnt - e0);
        end
        send(8'hC0);
        idle(1);
        checks++;
        if (offsets !== 32'h0) begin
            errors++;
            $display("FAIL timeout_shadow: got %h want 00000000", offsets);
        end
    endtask

    task automatic test_timeout_boundary;
        int e0;
        e0 = err_cnt;
        send(8'h40);
        repeat (T - 1) @(posedge clk);
        #1;
        send(8'hAB);
        send(8'hCD);
        send(8'hC0);
        idle(1);
        checks++;
        if (err_cnt - e0 !== 0 || offsets !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL byte_wins: errs=%0d ofs=%h want 0 0000abcd", err_cnt - e0, offsets);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC0;
        @(posedge clk);
        #1;
        in_data = 8'h00;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || commit_pulse !== 1'b1) begin
            errors++;
            $display("FAIL b2b_resume: ready=%b pulse=%b want 1 1", in_ready, commit_pulse);
        end
        @(posedge clk);
        #1;
        in_data = 8'h55;
        @(posedge clk);
        #1;
        in_data = 8'h66;
        @(posedge clk);
        #1;
        in_data = 8'hC0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(1);
        checks++;
        if (amps !== 32'h7FFF5566) begin
            errors++;
            $display("FAIL b2b_header: got %h want 7fff5566", amps);
        end
    endtask

    task automatic test_reset_midframe;
        int e0;
        int c0;
        send(8'h00);
        send(8'hAB);
        @(negedge clk);
        reset = 1'b0;
        #2;
        checks++;
        if (amps !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: amps=%h ready=%b want 0 1", amps, in_ready);
        end
        idle(2);
        @(negedge clk);
        reset = 1'b1;
        e0 = err_cnt;
        c0 = cmt_cnt;
        idle(3);
        checks++;
        if (err_cnt - e0 !== 0 || cmt_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL rst_no_strobe: errs=%0d cmts=%0d want 0 0", err_cnt - e0, cmt_cnt - c0);
        end
        send(8'hC0);
        idle(1);
        checks++;
        if (amps !== 32'h0 || commit_pulse !== 1'b1) begin
            errors++;
            $display("FAIL rst_discard: amps=%h pulse=%b want 0 1", amps, commit_pulse);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_amp_commit();
        test_double_write();
        test_bad_header();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
